// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst read controller and its skid buffer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order register buffer that absorbs the FIFO read latency.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [1:0]           occupancy,
    output logic [DATA_SIZE-1:0] head
);

    localparam logic [1:0] DEPTH = 2'(SKID_DEPTH);

    logic [DATA_SIZE-1:0] entry0;
    logic [DATA_SIZE-1:0] entry1;
    logic [1:0]           count;
    logic                 do_rd;

    assign do_rd     = rd_en && (count != 2'd0);
    assign occupancy = count;
    assign head      = entry0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else begin
            case ({wr_en, do_rd})
                2'b10: begin
                    if (count < DEPTH) begin
                        if (count == 2'd0) entry0 <= wr_data;
                        else               entry1 <= wr_data;
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous capture and dequeue: shift and refill, count unchanged.
                    if (count == 2'd1) begin
                        entry0 <= wr_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops N words from the FIFO and streams them out via valid/ready.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int LEN_SIZE  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    input  logic [LEN_SIZE-1:0]  cmd_len,
    output logic                 cmd_ready,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 pop,
    output logic                 can_read,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    input  logic                 out_ready,
    output logic                 done,
    output logic                 busy
);

    localparam logic [2:0] SKID_LIMIT = 3'(SKID_DEPTH);

    rd_state_t           state;
    rd_state_t           state_next;
    logic [LEN_SIZE-1:0] remaining;
    logic                inflight;
    logic [1:0]          occupancy;
    logic                deq;
    logic [2:0]          committed;
    logic                drain_now;

    rd_skid_buf #(
        .DATA_SIZE(DATA_SIZE)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (inflight),
        .wr_data   (fifo_data),
        .rd_en     (out_ready),
        .occupancy (occupancy),
        .head      (out_data)
    );

    assign out_valid = (occupancy != 2'd0);
    assign deq       = out_valid && out_ready;
    assign can_read  = pop;

    // Slots already claimed after this edge; crediting the dequeue keeps 1 word/cycle.
    assign committed = 3'(occupancy) + 3'(inflight) - 3'(deq);
    assign drain_now = (occupancy == 2'd0) || ((occupancy == 2'd1) && deq);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = (cmd_len == '0) ? DONE : READ;
            end
            READ: begin
                pop = !fifo_empty && (remaining != '0) && (committed < SKID_LIMIT);
                // Skip the FLUSH cycle when the last word leaves this very cycle.
                if ((remaining == '0) && !inflight && !pop)
                    state_next = drain_now ? DONE : FLUSH;
            end
            FLUSH: begin
                if (drain_now) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= pop;
            if ((state == IDLE) && cmd_valid)
                remaining <= cmd_len;
            else if (pop)
                remaining <= remaining - LEN_SIZE'(1);
        end
    end

endmodule
